// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: opcodes, instruction details and FSM states.
package mem_stage_pkg;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OPC_NOP   = 4'h0;
  localparam opcode_t OPC_ADD   = 4'h1;
  localparam opcode_t OPC_SUB   = 4'h2;
  localparam opcode_t OPC_AND   = 4'h3;
  localparam opcode_t OPC_OR    = 4'h4;
  localparam opcode_t OPC_LOAD  = 4'h5;
  localparam opcode_t OPC_STORE = 4'h6;
  localparam opcode_t OPC_JUMP  = 4'h7;
  localparam opcode_t OPC_BNEZ  = 4'h8;
  localparam opcode_t OPC_BEQZ  = 4'h9;

  typedef struct packed {
    logic        is_valid;
    opcode_t     op;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [15:0] imm;
  } InstructionDetails;

  typedef enum logic {
    MS_IDLE,
    MS_ACCESS
  } MemState;

  function automatic logic is_mem_op(input opcode_t op);
    return (op == OPC_LOAD) || (op == OPC_STORE);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage and the memory.
interface mem_stage_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic              mem_req;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_addr, mem_wdata, mem_we, mem_req,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_we, mem_req,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_stage_watchdog.sv
// Access watchdog: counts un-acked ACCESS cycles, flags the last allowed one.
module mem_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_async,
  input  logic clear,
  input  logic enable,
  output logic timeout
);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  assign timeout = enable && (count == LAST);

  // Count stalled cycles; hold at the terminal value, the FSM leaves ACCESS there.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async)                count <= '0;
    else if (clear)               count <= '0;
    else if (enable && !timeout)  count <= count + 1'b1;
  end
endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: forwards ALU results, performs LOAD/STORE over mem bus.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// MS_IDLE   | forwarding; an aligned valid LOAD/STORE starts an access
// MS_ACCESS | mem_req held until mem_ack or watchdog timeout
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_async,
  input  InstructionDetails details,
  input  logic [31:0]       alu_out,
  output logic              stall,
  output logic [3:0]        read_index,
  input  logic [31:0]       read_data,
  mem_stage_if.master       mem,
  output logic [31:0]       out,
  output InstructionDetails out_details
);
  MemState           state, state_nxt;
  InstructionDetails cap;
  logic              start, in_access, wd_timeout;

  assign start      = details.is_valid && is_mem_op(details.op) && (alu_out[1:0] == 2'b00);
  assign in_access  = (state == MS_ACCESS);
  assign read_index = details.rt;
  assign mem.mem_req = in_access;
  assign stall      = (!in_access && start) || (in_access && !mem.mem_ack && !wd_timeout);

  mem_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk       (clk),
    .rst_async (rst_async),
    .clear     (!in_access),
    .enable    (in_access && !mem.mem_ack),
    .timeout   (wd_timeout)
  );

  // State register.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) state <= MS_IDLE;
    else           state <= state_nxt;
  end

  // Next-state: enter on start, leave on ack or timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      MS_IDLE:   if (start) state_nxt = MS_ACCESS;
      MS_ACCESS: if (mem.mem_ack || wd_timeout) state_nxt = MS_IDLE;
      default:   state_nxt = MS_IDLE;
    endcase
  end

  // Datapath: captured request, bus outputs and writeback results.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      out           <= '0;
      out_details   <= '0;
      cap           <= '0;
      mem.mem_addr  <= '0;
      mem.mem_we    <= 1'b0;
      mem.mem_wdata <= '0;
    end else if (!in_access) begin
      if (start) begin
        cap                  <= details;
        mem.mem_addr         <= alu_out[ADDR_W-1:0];
        mem.mem_we           <= (details.op == OPC_STORE);
        mem.mem_wdata        <= read_data;
        out_details.is_valid <= 1'b0;
      end else if (details.is_valid && is_mem_op(details.op)) begin
        // misaligned access: dropped, forwarded as a bubble
        out                  <= '0;
        out_details          <= details;
        out_details.is_valid <= 1'b0;
      end else begin
        out         <= alu_out;
        out_details <= details;
      end
    end else if (mem.mem_ack) begin
      out         <= (cap.op == OPC_STORE) ? 32'h0 : mem.mem_rdata;
      out_details <= cap;
    end else if (wd_timeout) begin
      out                  <= '0;
      out_details          <= cap;
      out_details.is_valid <= 1'b0;
    end else begin
      out_details.is_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized instruction stream.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int TO = 4;

  logic              clk = 1'b0;
  logic              rst_async;
  InstructionDetails details;
  logic [31:0]       alu_out;
  logic              stall;
  logic [3:0]        read_index;
  logic [31:0]       read_data;
  logic [31:0]       out;
  InstructionDetails out_details;
  logic [31:0]       regs [16];

  int checks = 0;
  int errors = 0;

  mem_stage_if #(.ADDR_W(32)) mif ();

  mem_stage #(.ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_async   (rst_async),
    .details     (details),
    .alu_out     (alu_out),
    .stall       (stall),
    .read_index  (read_index),
    .read_data   (read_data),
    .mem         (mif.master),
    .out         (out),
    .out_details (out_details)
  );

  assign read_data = regs[read_index];

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic InstructionDetails mk(input logic v, input opcode_t op, input logic [3:0] rt);
    InstructionDetails d;
    d.is_valid = v;
    d.op       = op;
    d.rd       = 4'($urandom);
    d.rs       = 4'($urandom);
    d.rt       = rt;
    d.imm      = 16'($urandom);
    return d;
  endfunction

  // Present one instruction, act as memory, and check it against the rules.
  // ack_delay = number of un-acked ACCESS cycles before ack (>= TO: never acked).
  task automatic run_instr(input string name, input InstructionDetails d, input logic [31:0] alu,
                           input logic [31:0] rdata, input int ack_delay);
    logic is_mem, aligned, timed, stall_obs, consumed;
    int exp_req, stall_cnt, req_cnt, cyc;
    logic [31:0] exp_wdata;
    InstructionDetails exp_d;
    is_mem    = d.is_valid && (d.op == OPC_LOAD || d.op == OPC_STORE);
    aligned   = (alu[1:0] == 2'b00);
    timed     = is_mem && aligned && (ack_delay >= TO);
    exp_req   = !(is_mem && aligned) ? 0 : (timed ? TO : ack_delay + 1);
    stall_cnt = 0; req_cnt = 0; cyc = 0; consumed = 1'b0;
    details   = d;
    alu_out   = alu;
    exp_wdata = regs[d.rt];
    while (!consumed && cyc < 40) begin
      #1;
      if (mif.mem_req) begin
        req_cnt++;
        mif.mem_ack   = (req_cnt == ack_delay + 1);
        mif.mem_rdata = mif.mem_ack ? rdata : $urandom;
        check_eq({name, ":addr"}, 64'(mif.mem_addr), 64'(alu));
        check_eq({name, ":we"}, 64'(mif.mem_we), 64'(d.op == OPC_STORE));
        if (d.op == OPC_STORE) check_eq({name, ":wdata"}, 64'(mif.mem_wdata), 64'(exp_wdata));
      end else begin
        mif.mem_ack   = 1'($urandom_range(0, 1));
        mif.mem_rdata = $urandom;
      end
      if (cyc == 0) check_eq({name, ":read_index"}, 64'(read_index), 64'(d.rt));
      #1;
      stall_obs = stall;
      if (stall_obs) stall_cnt++;
      @(posedge clk);
      #1;
      mif.mem_ack = 1'b0;
      cyc++;
      if (!stall_obs) consumed = 1'b1;
      else begin
        check_eq({name, ":bubble"}, 64'(out_details.is_valid), 64'(0));
        regs[d.rt] = $urandom;
      end
    end
    check_eq({name, ":consumed"}, 64'(consumed), 64'(1));
    check_eq({name, ":req_cycles"}, 64'(req_cnt), 64'(exp_req));
    check_eq({name, ":stall_cycles"}, 64'(stall_cnt), 64'(exp_req));
    exp_d = d;
    if (!is_mem) begin
      check_eq({name, ":out"}, 64'(out), 64'(alu));
      check_eq({name, ":details"}, 64'(out_details), 64'(exp_d));
    end else if (!aligned) begin
      exp_d.is_valid = 1'b0;
      check_eq({name, ":out"}, 64'(out), 64'(0));
      check_eq({name, ":details"}, 64'(out_details), 64'(exp_d));
    end else if (!timed) begin
      check_eq({name, ":out"}, 64'(out), 64'((d.op == OPC_LOAD) ? rdata : 32'h0));
      check_eq({name, ":details"}, 64'(out_details), 64'(exp_d));
    end else begin
      exp_d.is_valid = 1'b0;
      check_eq({name, ":details"}, 64'(out_details), 64'(exp_d));
    end
  endtask

  initial begin
    opcode_t ops [10];
    ops = '{OPC_NOP, OPC_ADD, OPC_SUB, OPC_AND, OPC_OR,
            OPC_LOAD, OPC_STORE, OPC_JUMP, OPC_BNEZ, OPC_BEQZ};
    for (int i = 0; i < 16; i++) regs[i] = $urandom;
    rst_async     = 1'b1;
    details       = '0;
    alu_out       = '0;
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = '0;
    #12;
    check_eq("rst:out", 64'(out), 64'(0));
    check_eq("rst:details", 64'(out_details), 64'(0));
    check_eq("rst:req", 64'(mif.mem_req), 64'(0));
    check_eq("rst:we", 64'(mif.mem_we), 64'(0));
    check_eq("rst:addr", 64'(mif.mem_addr), 64'(0));
    check_eq("rst:wdata", 64'(mif.mem_wdata), 64'(0));
    check_eq("rst:stall", 64'(stall), 64'(0));
    #10;
    rst_async = 1'b0;
    @(posedge clk);
    #1;

    run_instr("add", mk(1'b1, OPC_ADD, 4'd1), 32'h1234, 32'h0, 0);
    run_instr("load", mk(1'b1, OPC_LOAD, 4'd2), 32'h40, 32'hCAFEF00D, 2);
    regs[3] = 32'hDEAD;
    run_instr("store", mk(1'b1, OPC_STORE, 4'd3), 32'h80, 32'h0, 0);
    run_instr("misaligned", mk(1'b1, OPC_LOAD, 4'd4), 32'h42, 32'h0, 0);
    run_instr("timeout", mk(1'b1, OPC_LOAD, 4'd5), 32'h100, 32'h0, 99);
    run_instr("after_to", mk(1'b1, OPC_SUB, 4'd6), 32'h5555, 32'h0, 0);
    run_instr("jump", mk(1'b1, OPC_JUMP, 4'd7), 32'h0BAD_0001, 32'h0, 0);
    run_instr("invalid_ld", mk(1'b0, OPC_LOAD, 4'd8), 32'h200, 32'h0, 0);

    // Reset in the second ACCESS cycle.
    details     = mk(1'b1, OPC_LOAD, 4'd9);
    alu_out     = 32'h300;
    mif.mem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("midrst:req_before", 64'(mif.mem_req), 64'(1));
    rst_async = 1'b1;
    #1;
    check_eq("midrst:req", 64'(mif.mem_req), 64'(0));
    check_eq("midrst:details", 64'(out_details), 64'(0));
    check_eq("midrst:out", 64'(out), 64'(0));
    details = '0;
    #2;
    rst_async = 1'b0;
    @(posedge clk); #1;
    check_eq("midrst:req_after", 64'(mif.mem_req), 64'(0));
    run_instr("post_rst_add", mk(1'b1, OPC_ADD, 4'd10), 32'hA5A5_0000, 32'h0, 0);

    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      run_instr("rand", mk(1'($urandom_range(0, 9) != 0), ops[$urandom_range(0, 9)],
                4'($urandom)), a, $urandom, int'($urandom_range(0, 5)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL sim_time_limit observed=expired expected=finish");
    $fatal(1, "time limit");
  end
endmodule
